// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle 16-bit shift/rotate engine.
// Moves the working register by up to two bit positions per clock and
// reports completion with a start/busy/done handshake. The op encoding
// matches the single-cycle barrel shifter stages.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; o_out holds the last result
//   ST_SHIFT | applying 1- or 2-bit steps until the remaining count is 0
//   ST_DONE  | one-cycle done pulse; a new start is accepted here too
module iter_shifter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [3:0]  i_amt,
    input  logic [15:0] i_data_in,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROL = 2'd0;
    localparam logic [1:0] OP_SLL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_SRL = 2'd3;

    state_t      r_state;
    logic [15:0] r_work;
    logic [1:0]  r_op;
    logic [3:0]  r_rem;

    state_t      w_state_nxt;
    logic [15:0] w_work_nxt;
    logic [1:0]  w_op_nxt;
    logic [3:0]  w_rem_nxt;

    // One step of the selected operation by one (i_dbl=0) or two (i_dbl=1)
    // positions. SRA replicates the current sign bit on every step, so a
    // chain of steps equals a single arithmetic shift by the total amount.
    function automatic logic [15:0] f_step(
        input logic [15:0] i_w,
        input logic [1:0]  i_sel,
        input logic        i_dbl
    );
        logic [15:0] v_res;
        v_res = i_w;
        case (i_sel)
            OP_ROL:  v_res = i_dbl ? {i_w[13:0], i_w[15:14]} : {i_w[14:0], i_w[15]};
            OP_SLL:  v_res = i_dbl ? {i_w[13:0], 2'b00}      : {i_w[14:0], 1'b0};
            OP_SRA:  v_res = i_dbl ? {{2{i_w[15]}}, i_w[15:2]} : {i_w[15], i_w[15:1]};
            OP_SRL:  v_res = i_dbl ? {2'b00, i_w[15:2]}      : {1'b0, i_w[15:1]};
            default: v_res = i_w;
        endcase
        return v_res;
    endfunction

    // Next-state, load and step logic.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_work_nxt  = i_data_in;
                    w_op_nxt    = i_op;
                    w_rem_nxt   = i_amt;
                    // A zero amount skips SHIFT so busy never rises.
                    w_state_nxt = (i_amt == 4'd0) ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (r_rem >= 4'd2) begin
                    w_work_nxt = f_step(r_work, r_op, 1'b1);
                    w_rem_nxt  = r_rem - 4'd2;
                end else if (r_rem == 4'd1) begin
                    w_work_nxt = f_step(r_work, r_op, 1'b0);
                    w_rem_nxt  = 4'd0;
                end
                // Start is deliberately not looked at here; it is not queued.
                if (w_rem_nxt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= 16'h0000;
            r_op    <= 2'd0;
            r_rem   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        o_busy = (r_state == ST_SHIFT);
        o_done = (r_state == ST_DONE);
        o_out  = r_work;
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter with hand-computed expected values.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] out_val;

    int n_tests = 0;
    int n_fail  = 0;

    iter_shifter dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_op      (op),
        .i_amt     (amt),
        .i_data_in (data_in),
        .o_busy    (busy),
        .o_done    (done),
        .o_out     (out_val)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called from the low phase: raise start, let edge E0 sample it, then
    // scramble the inputs to show they only matter on the load edge.
    task automatic apply(input logic [1:0] a_op, input logic [3:0] a_amt, input logic [15:0] a_data);
        start   = 1'b1;
        op      = a_op;
        amt     = a_amt;
        data_in = a_data;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = ~a_op;
        amt     = ~a_amt;
        data_in = 16'hDEAD;
    endtask

    // Samples each low phase after E0; done must appear at sample index k
    // with exactly k busy samples before it. Returns in the done cycle.
    task automatic wait_done(input string tag, input int exp_k, input logic [15:0] exp_out);
        int cyc;
        int n_busy;
        int overlap;
        n_busy  = 0;
        overlap = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) break;
            if (busy) n_busy++;
        end
        check_val({tag, ".done_cycle"}, 16'(cyc), 16'(exp_k));
        check_val({tag, ".busy_cycles"}, 16'(n_busy), 16'(exp_k));
        check_val({tag, ".overlap"}, 16'(overlap), 16'd0);
        check_val({tag, ".out"}, out_val, exp_out);
    endtask

    // One cycle after done with no new start: idle, result held.
    task automatic check_after(input string tag, input logic [15:0] exp_out);
        @(negedge clk);
        check_val({tag, ".done_pulse"}, {15'd0, done}, 16'd0);
        check_val({tag, ".idle_busy"}, {15'd0, busy}, 16'd0);
        check_val({tag, ".held"}, out_val, exp_out);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        amt     = 4'd0;
        data_in = 16'h0000;
        #12;
        check_val("reset.busy", {15'd0, busy}, 16'd0);
        check_val("reset.done", {15'd0, done}, 16'd0);
        check_val("reset.out", out_val, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // rotate left by 1
        @(negedge clk);
        apply(2'd0, 4'd1, 16'h8001);
        wait_done("rol1", 1, 16'h0003);
        check_after("rol1", 16'h0003);

        // shift left by 4, then back-to-back rotate issued in the done cycle
        @(negedge clk);
        apply(2'd1, 4'd4, 16'h00F0);
        wait_done("sll4", 2, 16'h0F00);
        apply(2'd0, 4'd4, 16'h1234);
        wait_done("b2b_rol4", 2, 16'h2341);
        check_after("b2b_rol4", 16'h2341);

        // longest amount, arithmetic and logical right
        @(negedge clk);
        apply(2'd2, 4'd15, 16'h8000);
        wait_done("sra15", 8, 16'hFFFF);
        check_after("sra15", 16'hFFFF);
        @(negedge clk);
        apply(2'd3, 4'd15, 16'h8000);
        wait_done("srl15", 8, 16'h0001);
        check_after("srl15", 16'h0001);

        // arithmetic right of a positive value, odd amount
        @(negedge clk);
        apply(2'd2, 4'd3, 16'h7F00);
        wait_done("sra3_pos", 2, 16'h0FE0);

        // zero amount: straight to done, no busy
        @(negedge clk);
        apply(2'd0, 4'd0, 16'h1234);
        wait_done("amt0", 0, 16'h1234);
        check_after("amt0", 16'h1234);

        // start during SHIFT is ignored
        @(negedge clk);
        apply(2'd3, 4'd9, 16'hFFFF);
        @(negedge clk);
        check_val("ign.busy_mid", {15'd0, busy}, 16'd1);
        @(negedge clk);
        start   = 1'b1;
        op      = 2'd1;
        amt     = 4'd3;
        data_in = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign", 3, 16'h007F);
        check_after("ign", 16'h007F);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        apply(2'd1, 4'd12, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_mid.busy_before", {15'd0, busy}, 16'd1);
        check_val("rst_mid.out_before", out_val, 16'h0010);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid.busy", {15'd0, busy}, 16'd0);
        check_val("rst_mid.done", {15'd0, done}, 16'd0);
        check_val("rst_mid.out", out_val, 16'h0000);
        @(negedge clk);
        check_val("rst_hold.out", out_val, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_rel.busy", {15'd0, busy}, 16'd0);
        apply(2'd1, 4'd15, 16'h0001);
        wait_done("post_rst_sll15", 8, 16'h8000);
        check_after("post_rst_sll15", 16'h8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got still running expected finished");
        $fatal(1);
    end

endmodule
